// File: rtl/pkt_dispatch.sv
// Purpose : generic single-clock FIFO; a pop in the same cycle frees a slot for a push.
// Latency : 1 cycle from push to visible at pop_dat; pop_dat is the current head (show-ahead).
// Backpres: push_rdy low when full and not popping; caller decides what to do with refused data.
// Ports   : clk/nrst, push_vld/push_dat/push_rdy, pop_rdy/pop_dat, empty, full.
module pkt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    // Occupancy kept apart from the pointers so full and empty never alias.
    logic [AW:0] cnt_q;
    logic do_push;
    logic do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == FULL_CNT);
    assign do_pop   = pop_rdy && !empty;
    assign push_rdy = !full || do_pop;
    assign do_push  = push_vld && push_rdy;
    assign pop_dat  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointer increment wraps naturally.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end
endmodule

// Purpose : buffers received packets, looks up per-type enable mask, pulses consumers and waits for done.
// Latency : newpkt -> en_out 2 cycles when idle and empty; zero-mask packets dispatch every 2 cycles.
// Backpres: none upstream; packets arriving at a full FIFO (with no same-cycle pop) are dropped and counted.
// Ports   : packet in (newpkt/fPktType/destinationID), myNodeID, route config (cfg_*),
//           enable pulses (en_out/iAmDestination/pkt_type_out), done_in, status (busy/fifo_full/drop_cnt/timeout_cnt).
module pkt_dispatch #(
    parameter int                  ID_WIDTH   = 16,
    parameter int                  TYPE_WIDTH = 3,
    parameter int                  NUM_EN     = 4,
    parameter int                  FIFO_DEPTH = 4,
    parameter int                  TIMEOUT    = 255,
    parameter logic [ID_WIDTH-1:0] BCAST_ID   = {ID_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  newpkt,
    input  logic [TYPE_WIDTH-1:0] fPktType,
    input  logic [ID_WIDTH-1:0]   destinationID,
    input  logic [ID_WIDTH-1:0]   myNodeID,
    input  logic                  cfg_we,
    input  logic [TYPE_WIDTH-1:0] cfg_type,
    input  logic [NUM_EN-1:0]     cfg_mask,
    output logic [NUM_EN-1:0]     en_out,
    output logic                  iAmDestination,
    output logic [TYPE_WIDTH-1:0] pkt_type_out,
    input  logic [NUM_EN-1:0]     done_in,
    output logic                  busy,
    output logic                  fifo_full,
    output logic [7:0]            drop_cnt,
    output logic [7:0]            timeout_cnt
);
    localparam int NTYPES = 1 << TYPE_WIDTH;
    localparam int TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // Default route masks for types 7..0 (bit0=QTU, bit1=MNI, bit2=KCH, bit3=reward).
    localparam logic [7:0][3:0] ROUTE_INIT = {4'b0000, 4'b1001, 4'b1001, 4'b1010,
                                              4'b0001, 4'b1100, 4'b0110, 4'b1010};

    typedef struct packed {
        logic [TYPE_WIDTH-1:0] ptype;
        logic [ID_WIDTH-1:0]   dest;
    } hdr_t;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT} state_t;

    // Types beyond the default table start unrouted; narrow NUM_EN truncates the default.
    function automatic logic [NUM_EN-1:0] init_mask(input int t);
        logic [NUM_EN+3:0] w;
        w = '0;
        if (t < 8) w[3:0] = ROUTE_INIT[t[2:0]];
        return w[NUM_EN-1:0];
    endfunction

    hdr_t                  push_dat;
    hdr_t                  head;
    logic                  push_rdy;
    logic                  fifo_empty;
    logic                  pop;
    logic                  drop;
    logic [NUM_EN-1:0]     head_mask;
    logic [NUM_EN-1:0]     pend_nxt;
    logic [NUM_EN-1:0]     disp_left;
    logic [TW-1:0]         timer_nxt;
    logic                  timed_out;

    state_t                state_q;
    logic [NUM_EN-1:0]     route_q [NTYPES];
    logic [NUM_EN-1:0]     en_q;
    logic                  iam_q;
    logic [TYPE_WIDTH-1:0] ptype_q;
    logic [NUM_EN-1:0]     pending_q;
    logic [TW-1:0]         timer_q;
    logic [7:0]            drop_q;
    logic [7:0]            tmo_q;

    assign push_dat = {fPktType, destinationID};
    assign pop      = (state_q == S_IDLE) && !fifo_empty;
    assign drop     = newpkt && !push_rdy;

    pkt_fifo #(
        .W     ($bits(hdr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .nrst     (nrst),
        .push_vld (newpkt),
        .push_dat (push_dat),
        .push_rdy (push_rdy),
        .pop_rdy  (pop),
        .pop_dat  (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // The enable pulse is registered on the pop edge, so a table write landing on that
    // same edge is forwarded; a write during the dispatch cycle itself is too late to matter.
    assign head_mask = (cfg_we && (cfg_type == head.ptype)) ? cfg_mask : route_q[head.ptype];

    // Done pulses during the dispatch cycle already count against the fresh mask.
    assign disp_left = en_q & ~done_in;
    assign pend_nxt  = pending_q & ~done_in;
    assign timer_nxt = timer_q + 1'b1;
    assign timed_out = (TIMEOUT != 0) && (timer_nxt == TW'(TIMEOUT));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int t = 0; t < NTYPES; t++) begin
                route_q[t] <= init_mask(t);
            end
        end else if (cfg_we) begin
            route_q[cfg_type] <= cfg_mask;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            en_q      <= '0;
            iam_q     <= 1'b0;
            ptype_q   <= '0;
            pending_q <= '0;
            timer_q   <= '0;
            drop_q    <= '0;
            tmo_q     <= '0;
        end else begin
            en_q  <= '0;
            iam_q <= 1'b0;
            if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        en_q    <= head_mask;
                        iam_q   <= (head.dest == myNodeID) || (head.dest == BCAST_ID);
                        ptype_q <= head.ptype;
                        state_q <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    pending_q <= disp_left;
                    timer_q   <= '0;
                    state_q   <= (disp_left == '0) ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    pending_q <= pend_nxt;
                    timer_q   <= timer_nxt;
                    if (pend_nxt == '0) begin
                        state_q <= S_IDLE;
                    end else if (timed_out) begin
                        if (tmo_q != 8'hFF) tmo_q <= tmo_q + 8'd1;
                        pending_q <= '0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign en_out         = en_q;
    assign iAmDestination = iam_q;
    assign pkt_type_out   = ptype_q;
    assign busy           = (state_q != S_IDLE);
    assign drop_cnt       = drop_q;
    assign timeout_cnt    = tmo_q;
endmodule

// File: tb/tb_pkt_dispatch.sv
module tb_pkt_dispatch;
    logic        clk = 1'b0;
    logic        nrst;
    logic        newpkt;
    logic [2:0]  fPktType;
    logic [15:0] destinationID;
    logic [15:0] myNodeID;
    logic        cfg_we;
    logic [2:0]  cfg_type;
    logic [3:0]  cfg_mask;
    logic [3:0]  en_out;
    logic        iAmDestination;
    logic [2:0]  pkt_type_out;
    logic [3:0]  done_in;
    logic        busy;
    logic        fifo_full;
    logic [7:0]  drop_cnt;
    logic [7:0]  timeout_cnt;

    pkt_dispatch dut (
        .clk            (clk),
        .nrst           (nrst),
        .newpkt         (newpkt),
        .fPktType       (fPktType),
        .destinationID  (destinationID),
        .myNodeID       (myNodeID),
        .cfg_we         (cfg_we),
        .cfg_type       (cfg_type),
        .cfg_mask       (cfg_mask),
        .en_out         (en_out),
        .iAmDestination (iAmDestination),
        .pkt_type_out   (pkt_type_out),
        .done_in        (done_in),
        .busy           (busy),
        .fifo_full      (fifo_full),
        .drop_cnt       (drop_cnt),
        .timeout_cnt    (timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [15:0] d;
    } pkt_t;

    int         total = 0;
    int         bad = 0;
    logic       busy_prev = 1'b0;
    pkt_t       exp_q[$];
    logic [3:0] route_m [8];
    int         drop_m = 0;
    logic [3:0] last_mask = 4'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: remember busy, then step to the next falling edge.
    task automatic cyc();
        busy_prev = busy;
        @(negedge clk);
    endtask

    task automatic reset_model();
        route_m = '{4'b1010, 4'b0110, 4'b1100, 4'b0001, 4'b1010, 4'b1001, 4'b1001, 4'b0000};
        exp_q.delete();
        drop_m = 0;
    endtask

    task automatic send_pkt(input logic [2:0] t, input logic [15:0] d, input bit acc);
        pkt_t p;
        p.t = t;
        p.d = d;
        newpkt = 1'b1;
        fPktType = t;
        destinationID = d;
        if (acc) exp_q.push_back(p);
        else drop_m++;
        cyc();
        newpkt = 1'b0;
    endtask

    // Dispatch is the first busy cycle after an idle one.
    task automatic check_head(input string tag);
        pkt_t p;
        chk({tag, "_queued"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            last_mask = route_m[p.t];
            chk({tag, "_en"}, 32'(en_out), 32'(route_m[p.t]));
            chk({tag, "_iam"}, 32'(iAmDestination), 32'((p.d == myNodeID) || (p.d == 16'hFFFF)));
            chk({tag, "_type"}, 32'(pkt_type_out), 32'(p.t));
        end
    endtask

    task automatic wait_disp(input int bound, input string tag);
        int n;
        n = 0;
        while (!(busy && !busy_prev) && n < bound) begin
            cyc();
            n++;
        end
        chk({tag, "_seen"}, 32'(busy && !busy_prev), 32'd1);
        if (busy && !busy_prev) check_head(tag);
    endtask

    task automatic finish_wait(input logic [3:0] mask, input string tag);
        int n;
        done_in = mask;
        cyc();
        done_in = 4'h0;
        n = 0;
        while (busy && n < 10) begin
            cyc();
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int   n;
        logic seen;
        pkt_t p;

        nrst = 1'b0; newpkt = 1'b0; fPktType = 3'd0; destinationID = 16'h0; myNodeID = 16'h0;
        cfg_we = 1'b0; cfg_type = 3'd0; cfg_mask = 4'h0; done_in = 4'h0;
        reset_model();
        repeat (2) cyc();
        chk("rst_en", 32'(en_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_iam", 32'(iAmDestination), 32'd0);
        chk("rst_type", 32'(pkt_type_out), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_tmo", 32'(timeout_cnt), 32'd0);
        nrst = 1'b1;
        cyc();

        // Type 5 addressed to us: exact two-cycle latency, then wait for QTU and reward done.
        myNodeID = 16'h0007;
        send_pkt(3'd5, 16'h0007, 1'b1);
        chk("lat_early_en", 32'(en_out), 32'd0);
        chk("lat_early_busy", 32'(busy), 32'd0);
        cyc();
        chk("lat_disp", 32'(busy && !busy_prev), 32'd1);
        check_head("t5");
        cyc();
        chk("t5_pulse_len", 32'(en_out), 32'd0);
        chk("t5_wait_busy", 32'(busy), 32'd1);
        done_in = 4'b0001;
        cyc();
        done_in = 4'b0000;
        chk("t5_part_done", 32'(busy), 32'd1);
        cyc();
        chk("t5_still_wait", 32'(busy), 32'd1);
        done_in = 4'b1000;
        cyc();
        done_in = 4'b0000;
        chk("t5_all_done", 32'(busy), 32'd0);

        // Broadcast and foreign destinations.
        myNodeID = 16'h0003;
        send_pkt(3'd0, 16'hFFFF, 1'b1);
        wait_disp(5, "bcast");
        finish_wait(last_mask, "bcast");
        send_pkt(3'd0, 16'h0004, 1'b1);
        wait_disp(5, "other");
        finish_wait(last_mask, "other");

        // Unrouted type 7: no pulse, busy for a single cycle; then route it to KCH.
        send_pkt(3'd7, 16'h0003, 1'b1);
        wait_disp(5, "t7def");
        cyc();
        chk("t7def_busy1", 32'(busy), 32'd0);
        cfg_we = 1'b1; cfg_type = 3'd7; cfg_mask = 4'b0100;
        route_m[7] = 4'b0100;
        cyc();
        cfg_we = 1'b0;
        send_pkt(3'd7, 16'h0003, 1'b1);
        wait_disp(5, "t7cfg");
        finish_wait(last_mask, "t7cfg");

        // Timeout: type 1 never completes, a type 3 waits behind it.
        send_pkt(3'd1, 16'h0003, 1'b1);
        send_pkt(3'd3, 16'h0003, 1'b1);
        wait_disp(5, "tmo1");
        n = 0;
        while (busy && n < 400) begin
            n++;
            cyc();
        end
        chk("tmo_busy_cycles", 32'(n), 32'd256);
        chk("tmo_cnt", 32'(timeout_cnt), 32'd1);
        wait_disp(5, "tmo_next");
        finish_wait(last_mask, "tmo_next");

        // Overflow while stalled in WAIT: four buffered, two dropped.
        send_pkt(3'd5, 16'h0003, 1'b1);
        wait_disp(5, "ovf_hold");
        send_pkt(3'd0, 16'h0010, 1'b1);
        send_pkt(3'd1, 16'h0011, 1'b1);
        send_pkt(3'd2, 16'h0003, 1'b1);
        send_pkt(3'd3, 16'h0013, 1'b1);
        send_pkt(3'd4, 16'h0014, 1'b0);
        send_pkt(3'd6, 16'h0015, 1'b0);
        chk("ovf_full", 32'(fifo_full), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'(drop_m));
        finish_wait(4'b1001, "ovf_hold");
        // FIFO full and FSM idle: this push shares its edge with a pop.
        send_pkt(3'd6, 16'hFFFF, 1'b1);
        chk("pp_disp", 32'(busy && !busy_prev), 32'd1);
        check_head("pp0");
        chk("pp_nodrop", 32'(drop_cnt), 32'(drop_m));
        chk("pp_full", 32'(fifo_full), 32'd1);
        for (int k = 0; k < 4; k++) begin
            finish_wait(last_mask, "drain");
            wait_disp(5, "drain");
        end
        finish_wait(last_mask, "drain_last");
        chk("drain_empty", 32'(fifo_full), 32'd0);

        // Randomised traffic, done pulses and table writes against the queue model.
        myNodeID = 16'h0042;
        for (int i = 0; i < 1200; i++) begin
            if (busy && !busy_prev) check_head("rnd");
            else chk("rnd_quiet_en", 32'(en_out), 32'd0);
            if (i >= 600 && exp_q.size() == 0 && !busy) break;
            done_in = 4'($urandom_range(0, 15));
            newpkt = 1'b0;
            cfg_we = 1'b0;
            if (i < 600 && exp_q.size() < 4 && $urandom_range(0, 2) == 0) begin
                p.t = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 2))
                    0:       p.d = myNodeID;
                    1:       p.d = 16'hFFFF;
                    default: p.d = 16'($urandom);
                endcase
                newpkt = 1'b1;
                fPktType = p.t;
                destinationID = p.d;
                exp_q.push_back(p);
            end
            if ($urandom_range(0, 15) == 0) begin
                cfg_we = 1'b1;
                cfg_type = 3'($urandom_range(0, 7));
                cfg_mask = 4'($urandom_range(0, 15));
                route_m[cfg_type] = cfg_mask;
            end
            cyc();
        end
        newpkt = 1'b0;
        cfg_we = 1'b0;
        done_in = 4'h0;
        chk("rnd_all_dispatched", 32'(exp_q.size()), 32'd0);
        chk("rnd_drop", 32'(drop_cnt), 32'(drop_m));
        chk("rnd_tmo", 32'(timeout_cnt), 32'd1);

        // Reset mid-WAIT with three packets queued.
        send_pkt(3'd5, 16'h0042, 1'b1);
        wait_disp(5, "rwait");
        send_pkt(3'd0, 16'h0042, 1'b1);
        send_pkt(3'd1, 16'h0042, 1'b1);
        send_pkt(3'd2, 16'h0042, 1'b1);
        nrst = 1'b0;
        cyc();
        chk("mrst_en", 32'(en_out), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_iam", 32'(iAmDestination), 32'd0);
        chk("mrst_type", 32'(pkt_type_out), 32'd0);
        chk("mrst_full", 32'(fifo_full), 32'd0);
        chk("mrst_drop", 32'(drop_cnt), 32'd0);
        chk("mrst_tmo", 32'(timeout_cnt), 32'd0);
        nrst = 1'b1;
        reset_model();
        seen = 1'b0;
        repeat (10) begin
            cyc();
            seen = seen | busy | (|en_out);
        end
        chk("mrst_no_pulse", 32'(seen), 32'd0);
        // Route table is back at its defaults: type 7 is unrouted again.
        send_pkt(3'd7, 16'h0042, 1'b1);
        wait_disp(5, "post_rst");
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
